// File: rtl/sync_line_sequencer_if.sv
// Signal bundle between the csync separator pulses and the line/field
// sequencer outputs consumed by downstream video timing.
`timescale 1ns/1ps
interface sync_line_sequencer_if;
    logic       hsync_pulse;
    logic       vsync_pulse;
    logic       line_start;
    logic       field_start;
    logic [9:0] line_number;
    logic       field;
    logic       locked;
    logic       field_valid;

    // Pulse source side (sync separator or testbench)
    modport master (
        output hsync_pulse,
        output vsync_pulse,
        input  line_start,
        input  field_start,
        input  line_number,
        input  field,
        input  locked,
        input  field_valid
    );

    // Sequencer side
    modport slave (
        input  hsync_pulse,
        input  vsync_pulse,
        output line_start,
        output field_start,
        output line_number,
        output field,
        output locked,
        output field_valid
    );
endinterface

// File: rtl/sync_line_sequencer.sv
// Flywheel line/field sequencer for the PAL 576i sync regenerator.
// Accepts hsync pulses near the expected line period, synthesises line
// starts when they go missing, and numbers lines 1..625 with field identity
// re-anchored by vsync.
`timescale 1ns/1ps
module sync_line_sequencer #(
    parameter int LINE_PERIOD = 5184,
    parameter int LINE_TOL    = 200,
    parameter int LOCK_COUNT  = 8,
    parameter int MISS_LIMIT  = 16,
    parameter int VSYNC_SPLIT = 2592
) (
    input  logic                  clk,
    input  logic                  nReset,
    sync_line_sequencer_if.slave  bus
);

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W = $clog2(MISS_LIMIT + 1);

    localparam logic [12:0] WIN_LO    = 13'(LINE_PERIOD - LINE_TOL);
    localparam logic [12:0] WIN_HI    = 13'(LINE_PERIOD + LINE_TOL);
    localparam logic [12:0] SPLIT     = 13'(VSYNC_SPLIT);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_LIMIT);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        COAST   = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [12:0]         timer_reg, timer_next;
    logic [GOOD_W-1:0]   good_reg, good_next, good_inc;
    logic [MISS_W-1:0]   miss_reg, miss_next, miss_inc;

    logic                hsync_in_window;
    logic                timer_expired;
    logic                line_event;
    logic                lock_drop;
    logic                in_lock;
    logic [12:0]         vsync_phase;

    logic                line_start_reg;
    logic                field_start_reg, field_start_next;
    logic [9:0]          line_reg, line_next;
    logic                field_reg, field_next;
    logic                locked_reg, locked_next;
    logic                field_valid_reg, field_valid_next;

    // Acceptance window and flywheel timeout derived from the phase timer
    always_comb begin
        hsync_in_window = bus.hsync_pulse && (timer_reg >= WIN_LO) && (timer_reg <= WIN_HI);
        timer_expired   = (timer_reg == WIN_HI);
        good_inc        = good_reg + 1'b1;
        miss_inc        = miss_reg + 1'b1;
        in_lock         = (state_reg == LOCKED) || (state_reg == COAST);
    end

    // Lock state machine: decides when a line start happens and lock transitions
    always_comb begin
        state_next = state_reg;
        good_next  = good_reg;
        miss_next  = miss_reg;
        line_event = 1'b0;
        lock_drop  = 1'b0;
        case (state_reg)
            SEARCH: begin
                if (bus.hsync_pulse) begin
                    line_event = 1'b1;
                    good_next  = '0;
                    state_next = ACQUIRE;
                end
            end
            ACQUIRE: begin
                if (bus.hsync_pulse) begin
                    line_event = 1'b1;
                    if (hsync_in_window) begin
                        good_next = good_inc;
                        if (good_inc == GOOD_LAST) begin
                            state_next = LOCKED;
                        end
                    end else begin
                        good_next = '0;
                    end
                end else if (timer_reg > WIN_HI) begin
                    state_next = SEARCH;
                end
            end
            LOCKED: begin
                // Out-of-window edges (equalising/serration) are ignored here
                if (hsync_in_window) begin
                    line_event = 1'b1;
                    miss_next  = '0;
                end else if (timer_expired) begin
                    line_event = 1'b1;
                    miss_next  = MISS_W'(1);
                    state_next = COAST;
                end
            end
            COAST: begin
                if (hsync_in_window) begin
                    line_event = 1'b1;
                    miss_next  = '0;
                    state_next = LOCKED;
                end else if (timer_expired) begin
                    line_event = 1'b1;
                    miss_next  = miss_inc;
                    if (miss_inc == MISS_LAST) begin
                        state_next = SEARCH;
                        lock_drop  = 1'b1;
                    end
                end
            end
            default: state_next = SEARCH;
        endcase
    end

    // Phase timer restarts on every line start and saturates when idle
    always_comb begin
        timer_next = timer_reg;
        if (line_event) begin
            timer_next = '0;
        end else if (timer_reg != 13'h1FFF) begin
            timer_next = timer_reg + 13'd1;
        end
    end

    // Line numbering: advance on locked line starts, then let vsync re-anchor
    always_comb begin
        line_next        = line_reg;
        field_next       = field_reg;
        field_start_next = 1'b0;
        field_valid_next = field_valid_reg;
        vsync_phase      = line_event ? 13'd0 : timer_reg;
        locked_next      = (state_next == LOCKED) || (state_next == COAST);

        if (line_event && in_lock) begin
            if (line_reg == 10'd625) begin
                line_next        = 10'd1;
                field_next       = 1'b0;
                field_start_next = 1'b1;
            end else if (line_reg == 10'd312) begin
                line_next        = 10'd313;
                field_next       = 1'b1;
                field_start_next = 1'b1;
            end else begin
                line_next        = line_reg + 10'd1;
            end
        end

        // A vsync coincident with a line start sees phase 0, i.e. field 0
        if (bus.vsync_pulse && in_lock) begin
            field_start_next = 1'b1;
            field_valid_next = 1'b1;
            if (vsync_phase < SPLIT) begin
                line_next  = 10'd1;
                field_next = 1'b0;
            end else begin
                line_next  = 10'd313;
                field_next = 1'b1;
            end
        end

        if (lock_drop) begin
            field_valid_next = 1'b0;
        end
    end

    // Lock state, phase timer and run counters
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_reg <= SEARCH;
            timer_reg <= '0;
            good_reg  <= '0;
            miss_reg  <= '0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            good_reg  <= good_next;
            miss_reg  <= miss_next;
        end
    end

    // Registered outputs, one cycle after the causing event
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            line_start_reg  <= 1'b0;
            field_start_reg <= 1'b0;
            line_reg        <= 10'd1;
            field_reg       <= 1'b0;
            locked_reg      <= 1'b0;
            field_valid_reg <= 1'b0;
        end else begin
            line_start_reg  <= line_event;
            field_start_reg <= field_start_next;
            line_reg        <= line_next;
            field_reg       <= field_next;
            locked_reg      <= locked_next;
            field_valid_reg <= field_valid_next;
        end
    end

    assign bus.line_start  = line_start_reg;
    assign bus.field_start = field_start_reg;
    assign bus.line_number = line_reg;
    assign bus.field       = field_reg;
    assign bus.locked      = locked_reg;
    assign bus.field_valid = field_valid_reg;

endmodule
